cnn_core_mul_share_arb: RTL and testbench
=========================================

# cnn_core_mul_share_arb

Round-robin arbiter sharing one signed 16×5→21-bit multiplier among `N_REQ` requesters in the CNN core. Each requester presents an operand pair with a valid/ready handshake. The block grants at most one request per cycle, multiplies the pair and returns the product tagged with the requester index through a single registered response stage with backpressure. It sits between the per-channel weight/activation sequencers and the accumulation logic, replacing per-channel multiplier instances.

## Interface
- `N_REQ`, 4: number of requesters, 2..16.
- `A_W`, 16: signed activation width. Fixed by the multiplier; not overridable in practice.
- `B_W`, 5: signed weight width. Fixed.
- `P_W`, 21: signed product width, `A_W+B_W`.
- `ID_W`, derived localparam, `$clog2(N_REQ)`.

- `ap_clk`, in, 1: clock; everything is rising-edge.
- `ap_rst`, in, 1: reset, synchronous, active-high.
- `req_valid`, in, `N_REQ`: per-requester operand valid.
- `req_ready`, out, `N_REQ`: per-requester accept. One-hot or zero.
- `req_a`, in, `N_REQ*A_W`: signed activations, requester i at bits `[i*A_W +: A_W]`.
- `req_b`, in, `N_REQ*B_W`: signed weights, requester i at bits `[i*B_W +: B_W]`.
- `rsp_valid`, out, 1: response register holds a product.
- `rsp_ready`, in, 1: downstream accepts the response.
- `rsp_id`, out, `ID_W`: index of the requester that produced `rsp_data`.
- `rsp_data`, out, `P_W`: signed product.

## Operation
- Reset values:
  - `rsp_valid=0`, `rsp_id=0`, `rsp_data=0`.
  - Priority pointer `ptr=0`.
  - `req_ready` is all zero while `ap_rst` is high.
- Slot free condition: `slot_free = !rsp_valid || rsp_ready`.
- Grant:
  - When `slot_free`, grant the first i with `req_valid[i]=1`, searching `ptr, ptr+1, …, N_REQ-1, 0, …, ptr-1`.
  - `req_ready[i]=1` only for the granted i.
  - A transfer occurs on requester i when `req_valid[i] && req_ready[i]`.
- Pointer update: on a transfer from requester i, `ptr <= (i+1) mod N_REQ`. With no transfer, `ptr` holds.
- Datapath on a transfer:
  - `rsp_data <= $signed(a_i) * $signed(b_i)`, computed full-width.
  - No overflow is possible: the extreme case -32768 × -16 = 524288 fits in 21 bits signed.
  - `rsp_id <= i`.
  - `rsp_valid <= 1`.
- Drain without refill: on `rsp_valid && rsp_ready` with no new transfer, `rsp_valid <= 0`. `rsp_id` and `rsp_data` hold their last values.
- Simultaneous drain and refill: the response register is overwritten in the same edge, giving full throughput of 1 product/cycle.
- Stall:
  - `rsp_valid && !rsp_ready` holds `rsp_*` stable and forces `req_ready=0`.
  - Requester operands must stay stable while `req_valid=1` and the request is not yet accepted.
- No request: `req_ready=0`, `ptr` unchanged.
- Reset mid-operation: a pending response is discarded. `ptr` returns to 0 on the edge where `ap_rst` is sampled high.
- Fairness: with all requesters continuously valid and `rsp_ready=1`, grants rotate 0,1,…,N_REQ-1,0,… Any continuously valid requester is served within `N_REQ` accepted transfers.

## Timing
- Latency: an accept at edge k makes the product visible on `rsp_*` after edge k, i.e. `rsp_valid` is high in cycle k+1.
- `req_ready` is combinational from `req_valid`, `ptr`, `rsp_valid` and `rsp_ready`. The multiplier and grant mux are combinational into the response register.
- All `rsp_*` outputs come straight from flops.
- No combinational path from `req_*` to `rsp_*`.
- Throughput: 1 transfer/cycle when `rsp_ready=1`. Zero transfers while stalled.
- Critical path: grant mux → 16×5 multiply → register. A single cycle is sufficient at the core clock target.

## Structure
- Package `cnn_core_mul_pkg`:
  - `A_W`, `B_W`, `P_W` constants.
  - Typedefs `act_t` (logic signed [15:0]), `wgt_t` (logic signed [4:0]), `prod_t` (logic signed [20:0]).
- Sub-module `cnn_core_rr_arb`:
  - Parameterised by `N_REQ`.
  - Inputs: request vector, `ptr`, `enable`.
  - Outputs: one-hot grant and the encoded index.
- The multiply uses the existing `cnn_core_mul_16s_5s_21_1_1` instance fed from the grant mux.
- Pointer and response registers live in the top module.

## Test plan
- Single request:
  - Stimulus: reset, then `req_valid=4'b0100`, a2=1000, b2=-3, `rsp_ready=1`.
  - Response: `req_ready=4'b0100` for one cycle; next cycle `rsp_valid=1`, `rsp_id=2`, `rsp_data=-3000`; `ptr=3`.
- Round-robin rotation:
  - Stimulus: all four requesters valid for 8 cycles, `rsp_ready=1`.
  - Response: `rsp_id` sequence 0,1,2,3,0,1,2,3 on consecutive cycles.
- Extremes:
  - a=-32768, b=-16 → `rsp_data=524288`.
  - a=32767, b=-16 → `rsp_data=-524272`.
  - a=-32768, b=15 → `rsp_data=-491520`.
- Backpressure:
  - Stimulus: response pending, `rsp_ready=0` for 3 cycles, requests 1 and 3 valid.
  - Response: `req_ready=0` and `rsp_*` stable for those cycles. On release, the drain and the grant to the next requester by the rotation occur in the same edge, with no bubble.
- Skip idle requesters:
  - Stimulus: `ptr=1`, only requester 0 valid.
  - Response: grant to 0, `ptr` becomes 1.
- Reset mid-operation:
  - Stimulus: `ap_rst=1` for one cycle while `rsp_valid=1` and `ptr=2`.
  - Response: after the edge, `rsp_valid=0`, `rsp_data=0`, `ptr=0`; `req_ready=0` during the reset cycle.

Source files
------------

// File: rtl/cnn_core_mul_pkg.sv
// rtl/cnn_core_mul_pkg.sv - operand/product widths and types for the shared CNN multiplier
package cnn_core_mul_pkg;

    localparam int A_W = 16;
    localparam int B_W = 5;
    localparam int P_W = A_W + B_W;

    typedef logic signed [A_W-1:0] act_t;
    typedef logic signed [B_W-1:0] wgt_t;
    typedef logic signed [P_W-1:0] prod_t;

endpackage

// File: rtl/cnn_core_mul_16s_5s_21_1_1.sv
// rtl/cnn_core_mul_16s_5s_21_1_1.sv - combinational signed 16x5 -> 21 multiplier
module cnn_core_mul_16s_5s_21_1_1
    import cnn_core_mul_pkg::*;
(
    input  act_t  din0,
    input  wgt_t  din1,
    output prod_t dout
);

    // Sign-extend both operands to the product width; the low P_W bits are exact.
    assign dout = prod_t'(din0) * prod_t'(din1);

endmodule

// File: rtl/cnn_core_rr_arb.sv
// rtl/cnn_core_rr_arb.sv - round-robin grant search starting at a priority pointer
module cnn_core_rr_arb #(
    parameter  int N_REQ = 4,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [ID_W-1:0]  ptr_i,
    input  logic             enable_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [ID_W-1:0]  idx_o,
    output logic             valid_o
);

    int idx;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        idx     = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(ptr_i) + k) % N_REQ;
            if (enable_i && !valid_o && req_i[idx]) begin
                valid_o      = 1'b1;
                grant_o[idx] = 1'b1;
                idx_o        = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/cnn_core_mul_share_arb.sv
// rtl/cnn_core_mul_share_arb.sv - round-robin sharing of one signed multiplier among N_REQ requesters
module cnn_core_mul_share_arb
    import cnn_core_mul_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*A_W-1:0]   req_a,
    input  logic [N_REQ*B_W-1:0]   req_b,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [P_W-1:0]         rsp_data
);

    logic [ID_W-1:0] ptr_q, ptr_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0] rsp_id_q, rsp_id_d;
    prod_t           rsp_data_q, rsp_data_d;

    logic            slot_free;
    logic            arb_en;
    logic            gnt_any;
    logic [ID_W-1:0] gnt_idx;
    act_t            a_sel;
    wgt_t            b_sel;
    prod_t           prod;

    assign slot_free = !rsp_valid_q || rsp_ready;
    assign arb_en    = slot_free && !ap_rst;

    cnn_core_rr_arb #(.N_REQ(N_REQ)) u_arb (
        .req_i    (req_valid),
        .ptr_i    (ptr_q),
        .enable_i (arb_en),
        .grant_o  (req_ready),
        .idx_o    (gnt_idx),
        .valid_o  (gnt_any)
    );

    assign a_sel = req_a[gnt_idx*A_W +: A_W];
    assign b_sel = req_b[gnt_idx*B_W +: B_W];

    cnn_core_mul_16s_5s_21_1_1 u_mul (
        .din0 (a_sel),
        .din1 (b_sel),
        .dout (prod)
    );

    // A grant is always a transfer, since the arbiter only grants valid requesters.
    always_comb begin
        ptr_d       = ptr_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        if (gnt_any) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = gnt_idx;
            rsp_data_d  = prod;
            ptr_d       = (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            ptr_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
        end else begin
            ptr_q       <= ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_cnn_core_mul_share_arb.sv
// tb/tb_cnn_core_mul_share_arb.sv - self-checking bench for the shared multiplier arbiter
module tb_cnn_core_mul_share_arb;

    localparam int N = 4;

    logic              ap_clk;
    logic              ap_rst;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*16-1:0]   req_a;
    logic [N*5-1:0]    req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [1:0]        rsp_id;
    logic [20:0]       rsp_data;

    logic signed [15:0] a_arr [N];
    logic signed [4:0]  b_arr [N];

    assign req_a = {a_arr[3], a_arr[2], a_arr[1], a_arr[0]};
    assign req_b = {b_arr[3], b_arr[2], b_arr[1], b_arr[0]};

    cnn_core_mul_share_arb #(.N_REQ(N)) dut (
        .ap_clk    (ap_clk),
        .ap_rst    (ap_rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: priority pointer plus the single response slot.
    int                 m_ptr;
    logic               m_valid;
    int                 m_id;
    logic signed [20:0] m_data;

    function automatic int model_grant();
        if (ap_rst) return -1;
        if (m_valid && !rsp_ready) return -1;
        for (int k = 0; k < N; k++) begin
            if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic step(output int g, output logic [N-1:0] rdy_obs, output logic [N-1:0] rdy_exp);
        #1;
        rdy_obs = req_ready;
        g       = model_grant();
        rdy_exp = (g >= 0) ? N'(1 << g) : '0;
        @(posedge ap_clk);
        if (ap_rst) begin
            m_ptr = 0; m_valid = 1'b0; m_id = 0; m_data = '0;
        end else if (g >= 0) begin
            m_valid = 1'b1;
            m_id    = g;
            m_data  = 21'(int'(a_arr[g]) * int'(b_arr[g]));
            m_ptr   = (g + 1) % N;
        end else if (rsp_ready) begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    task automatic do_reset();
        int g; logic [N-1:0] o, e;
        @(negedge ap_clk);
        ap_rst = 1'b1; req_valid = '0; rsp_ready = 1'b1;
        step(g, o, e);
        step(g, o, e);
        @(negedge ap_clk);
        ap_rst = 1'b0;
    endtask

    task automatic test_reset();
        int g; logic [N-1:0] o, e;
        @(negedge ap_clk);
        ap_rst = 1'b1; req_valid = '1; rsp_ready = 1'b1;
        step(g, o, e);
        n_checks++;
        if (o !== '0) begin n_fail++; $display("FAIL reset_ready: got %b want 0000", o); end
        n_checks++;
        if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_data !== 21'd0) begin
            n_fail++; $display("FAIL reset_rsp: got v=%b id=%0d d=%0d want 0/0/0", rsp_valid, rsp_id, rsp_data);
        end
        @(negedge ap_clk);
        ap_rst = 1'b0; req_valid = '0;
    endtask

    task automatic test_single();
        int g; logic [N-1:0] o, e;
        do_reset();
        req_valid = 4'b0100; a_arr[2] = 16'sd1000; b_arr[2] = -5'sd3; rsp_ready = 1'b1;
        step(g, o, e);
        n_checks++;
        if (o !== 4'b0100) begin n_fail++; $display("FAIL single_ready: got %b want 0100", o); end
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== 21'(-3000)) begin
            n_fail++; $display("FAIL single_rsp: got v=%b id=%0d d=%h want 1/2/%h", rsp_valid, rsp_id, rsp_data, 21'(-3000));
        end
        @(negedge ap_clk);
        req_valid = 4'b1111;
        step(g, o, e);
        n_checks++;
        if (o !== 4'b1000) begin n_fail++; $display("FAIL single_ptr: got %b want 1000", o); end
        @(negedge ap_clk);
        req_valid = '0;
        step(g, o, e);
    endtask

    task automatic test_rotation();
        int g; logic [N-1:0] o, e;
        do_reset();
        for (int i = 0; i < N; i++) begin a_arr[i] = 16'($urandom); b_arr[i] = 5'($urandom); end
        req_valid = '1; rsp_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step(g, o, e);
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'(k % N) || rsp_data !== m_data) begin
                n_fail++; $display("FAIL rotation[%0d]: got v=%b id=%0d d=%h want 1/%0d/%h", k, rsp_valid, rsp_id, rsp_data, k % N, m_data);
            end
            @(negedge ap_clk);
            if (g >= 0) begin a_arr[g] = 16'($urandom); b_arr[g] = 5'($urandom); end
        end
        req_valid = '0;
        step(g, o, e);
    endtask

    task automatic test_extremes();
        int g; logic [N-1:0] o, e; int j;
        logic signed [15:0] ea [3];
        logic signed [4:0]  eb [3];
        logic signed [20:0] ep [3];
        ea[0] = -16'sd32768; eb[0] = -5'sd16; ep[0] = 21'sd524288;
        ea[1] =  16'sd32767; eb[1] = -5'sd16; ep[1] = -21'sd524272;
        ea[2] = -16'sd32768; eb[2] =  5'sd15; ep[2] = -21'sd491520;
        for (int t = 0; t < 3; t++) begin
            @(negedge ap_clk);
            j = int'($urandom_range(N - 1));
            req_valid = '0; req_valid[j] = 1'b1; rsp_ready = 1'b1;
            a_arr[j] = ea[t]; b_arr[j] = eb[t];
            step(g, o, e);
            n_checks++;
            if (o !== N'(1 << j) || rsp_valid !== 1'b1 || rsp_data !== ep[t]) begin
                n_fail++; $display("FAIL extreme[%0d]: got rdy=%b v=%b d=%h want rdy=%b v=1 d=%h", t, o, rsp_valid, rsp_data, N'(1 << j), ep[t]);
            end
        end
        @(negedge ap_clk);
        req_valid = '0;
        step(g, o, e);
    endtask

    task automatic test_backpressure();
        int g; logic [N-1:0] o, e; logic [20:0] held;
        do_reset();
        for (int i = 0; i < N; i++) begin a_arr[i] = 16'($urandom); b_arr[i] = 5'($urandom); end
        req_valid = 4'b0001; rsp_ready = 1'b1;
        step(g, o, e);
        held = m_data;
        @(negedge ap_clk);
        req_valid = 4'b1010; rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step(g, o, e);
            n_checks++;
            if (o !== '0 || rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== held) begin
                n_fail++; $display("FAIL stall[%0d]: got rdy=%b v=%b id=%0d d=%h want 0000/1/0/%h", k, o, rsp_valid, rsp_id, rsp_data, held);
            end
            @(negedge ap_clk);
        end
        rsp_ready = 1'b1;
        step(g, o, e);
        n_checks++;
        if (o !== 4'b0010 || rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== m_data) begin
            n_fail++; $display("FAIL release: got rdy=%b v=%b id=%0d d=%h want 0010/1/1/%h", o, rsp_valid, rsp_id, rsp_data, m_data);
        end
        @(negedge ap_clk);
        req_valid = '0;
        step(g, o, e);
    endtask

    task automatic test_skip_idle();
        int g; logic [N-1:0] o, e;
        do_reset();
        req_valid = 4'b0001; rsp_ready = 1'b1;
        step(g, o, e);
        @(negedge ap_clk);
        step(g, o, e);
        n_checks++;
        if (o !== 4'b0001 || rsp_id !== 2'd0) begin
            n_fail++; $display("FAIL skip_idle: got rdy=%b id=%0d want 0001/0", o, rsp_id);
        end
        @(negedge ap_clk);
        req_valid = 4'b1111;
        step(g, o, e);
        n_checks++;
        if (o !== 4'b0010) begin n_fail++; $display("FAIL skip_ptr: got %b want 0010", o); end
        @(negedge ap_clk);
        req_valid = '0;
        step(g, o, e);
    endtask

    task automatic test_reset_mid();
        int g; logic [N-1:0] o, e;
        do_reset();
        req_valid = 4'b0010; rsp_ready = 1'b1;
        step(g, o, e);
        @(negedge ap_clk);
        ap_rst = 1'b1; req_valid = 4'b1111; rsp_ready = 1'b0;
        step(g, o, e);
        n_checks++;
        if (o !== '0) begin n_fail++; $display("FAIL rst_mid_ready: got %b want 0000", o); end
        n_checks++;
        if (rsp_valid !== 1'b0 || rsp_data !== 21'd0 || rsp_id !== 2'd0) begin
            n_fail++; $display("FAIL rst_mid_rsp: got v=%b id=%0d d=%h want 0/0/0", rsp_valid, rsp_id, rsp_data);
        end
        @(negedge ap_clk);
        ap_rst = 1'b0; rsp_ready = 1'b1;
        step(g, o, e);
        n_checks++;
        if (o !== 4'b0001) begin n_fail++; $display("FAIL rst_mid_ptr: got %b want 0001", o); end
        @(negedge ap_clk);
        req_valid = '0;
        step(g, o, e);
    endtask

    task automatic test_random();
        int g; logic [N-1:0] o, e;
        do_reset();
        req_valid = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i]) begin
                    req_valid[i] = ($urandom_range(9) < 6);
                    a_arr[i] = 16'($urandom); b_arr[i] = 5'($urandom);
                end
            end
            rsp_ready = ($urandom_range(3) != 0);
            step(g, o, e);
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL rand_ready[%0d]: got %b want %b", c, o, e); end
            n_checks++;
            if (rsp_valid !== m_valid || (m_valid && (rsp_id !== 2'(m_id) || rsp_data !== m_data))) begin
                n_fail++; $display("FAIL rand_rsp[%0d]: got v=%b id=%0d d=%h want %b/%0d/%h", c, rsp_valid, rsp_id, rsp_data, m_valid, m_id, m_data);
            end
            @(negedge ap_clk);
            if (g >= 0) req_valid[g] = 1'b0;
        end
        req_valid = '0;
        step(g, o, e);
    endtask

    initial begin
        ap_rst = 1'b1; req_valid = '0; rsp_ready = 1'b0;
        for (int i = 0; i < N; i++) begin a_arr[i] = '0; b_arr[i] = '0; end
        m_ptr = 0; m_valid = 1'b0; m_id = 0; m_data = '0;
        test_reset();
        test_single();
        test_rotation();
        test_extremes();
        test_backpressure();
        test_skip_idle();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
